mem_access: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline bundle (op, funct3, address, store data, writeback fields).
- Performs RISC-V loads and stores over a byte-wide synchronous RAM port, one byte per cycle, little-endian.
- Raises stall_req to the pipeline controller while an access is in flight.
- Presents registered writeback fields to the MEM/WB stage.

---
 rtl/mem_access_pkg.sv | 52 +++++
 rtl/mem_access_load_ext.sv | 28 ++
 rtl/mem_access.sv | 219 +++++++++++++++++++++
 tb/tb_mem_access.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: opcode/funct3 constants, widths, state encoding and small
// decode helpers shared by the MEM-stage byte-serial load/store unit.
package mem_access_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int XLEN_DEF   = 32;

    localparam logic [6:0] LOAD_OP  = 7'b0000011;
    localparam logic [6:0] STORE_OP = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [4:0] NULL_WD   = 5'd0;
    localparam logic [7:0] NULL_BYTE = 8'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_e;

    // True only for load/store opcodes carrying a funct3 we can execute.
    function automatic logic is_valid_access(input logic [6:0] op, input logic [2:0] f3);
        if (op == LOAD_OP)  return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        if (op == STORE_OP) return f3 inside {F3_B, F3_H, F3_W};
        return 1'b0;
    endfunction

    // Bytes moved by an access: 1, 2 or 4.
    function automatic logic [2:0] byte_count(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Halfwords need addr[0]==0, words need addr[1:0]==0.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// mem_load_ext: assembles the captured little-endian bytes and applies
// sign/zero extension selected by funct3 (purely combinational).
module mem_load_ext
    import mem_access_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [3:0][7:0]  bytes_i,
    input  logic [2:0]       funct3_i,
    output logic [XLEN-1:0]  data_o
);

    logic [31:0] word;
    assign word = bytes_i;

    // Select the extension rule for the access size.
    always_comb begin
        data_o = '0;
        case (funct3_i)
            F3_B:    data_o = {{(XLEN-8){word[7]}}, word[7:0]};
            F3_H:    data_o = {{(XLEN-16){word[15]}}, word[15:0]};
            F3_BU:   data_o = {{(XLEN-8){1'b0}}, word[7:0]};
            F3_HU:   data_o = {{(XLEN-16){1'b0}}, word[15:0]};
            default: data_o = {{(XLEN-32){1'b0}}, word};
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM-stage unit performing RISC-V loads/stores one byte per cycle
// over a byte-wide synchronous RAM, stalling the pipeline while busy.
// Build option: define MISALIGN_TRAP_EN to trap misaligned H/W accesses
// (no RAM traffic, writeback suppressed, misalign pulsed).
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int XLEN   = XLEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        in_wd,
    input  logic              in_wreg,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [6:0]        in_op,
    input  logic [2:0]        in_funct3,
    input  logic [ADDR_W-1:0] in_mem_addr,
    input  logic [XLEN-1:0]   in_reg,
    output logic              stall_req,
    output logic              ram_en,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic [4:0]        wb_wd,
    output logic              wb_wreg,
    output logic [XLEN-1:0]   wb_wdata,
    output logic              misalign
);

    state_e            state_q, state_d;
    logic              is_store_q, is_store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       sdata_q, sdata_d;
    logic [4:0]        wd_q, wd_d;
    logic              wreg_q, wreg_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [3:0][7:0]   bytes_q, bytes_d;
    logic              trap_q, trap_d;
    logic [4:0]        wb_wd_q, wb_wd_d;
    logic              wb_wreg_q, wb_wreg_d;
    logic [XLEN-1:0]   wb_wdata_q, wb_wdata_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_wr_q, ram_wr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;

    logic              mem_op;
    logic              in_trap;
    logic [2:0]        cnt_inc;
    logic [2:0]        last_cnt;
    logic [1:0]        cap_idx;
    logic [XLEN-1:0]   load_val;

    assign mem_op   = is_valid_access(in_op, in_funct3);
    assign cnt_inc  = cnt_q + 3'd1;
    assign last_cnt = byte_count(funct3_q) - 3'd1;
    // Byte issued on the previous cycle is the one arriving on ram_din now.
    assign cap_idx  = cnt_q[1:0] - 2'd1;

    mem_load_ext #(.XLEN(XLEN)) u_load_ext (
        .bytes_i  (bytes_q),
        .funct3_i (funct3_q),
        .data_o   (load_val)
    );

`ifdef MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    assign in_trap    = mem_op && is_misaligned(in_funct3, in_mem_addr[1:0]);
    assign misalign_d = (state_q == DONE) && trap_q;
    // Pulse the flag in the cycle the suppressed writeback becomes visible.
    always_ff @(posedge clk) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= misalign_d;
    end
    assign misalign = misalign_q;
`else
    assign in_trap  = 1'b0;
    assign misalign = 1'b0;
`endif

    // Next-state, RAM strobe, byte capture and writeback selection.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        wd_d       = wd_q;
        wreg_d     = wreg_q;
        cnt_d      = cnt_q;
        bytes_d    = bytes_q;
        trap_d     = trap_q;
        wb_wd_d    = wb_wd_q;
        wb_wreg_d  = wb_wreg_q;
        wb_wdata_d = wb_wdata_q;
        ram_en_d   = ram_en_q;
        ram_wr_d   = ram_wr_q;
        ram_addr_d = ram_addr_q;
        ram_dout_d = ram_dout_q;
        stall_req  = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    stall_req  = 1'b1;
                    is_store_d = (in_op == STORE_OP);
                    funct3_d   = in_funct3;
                    addr_d     = in_mem_addr;
                    sdata_d    = in_reg[31:0];
                    wd_d       = in_wd;
                    wreg_d     = in_wreg;
                    cnt_d      = 3'd0;
                    bytes_d    = '0;
                    wb_wd_d    = NULL_WD;
                    wb_wreg_d  = 1'b0;
                    wb_wdata_d = '0;
                    if (in_trap) begin
                        trap_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        trap_d     = 1'b0;
                        ram_en_d   = 1'b1;
                        ram_wr_d   = (in_op == STORE_OP);
                        ram_addr_d = in_mem_addr;
                        ram_dout_d = in_reg[7:0];
                        state_d    = ACCESS;
                    end
                end else begin
                    // Unsupported funct3 on a load/store opcode must not write a register.
                    wb_wd_d    = in_wd;
                    wb_wreg_d  = in_wreg && (in_op != LOAD_OP) && (in_op != STORE_OP);
                    wb_wdata_d = in_wdata;
                end
            end
            ACCESS: begin
                stall_req = 1'b1;
                cnt_d     = cnt_inc;
                if (!is_store_q && cnt_q != 3'd0) bytes_d[cap_idx] = ram_din;
                if (cnt_q == last_cnt) begin
                    ram_en_d   = 1'b0;
                    ram_wr_d   = 1'b0;
                    ram_dout_d = NULL_BYTE;
                    state_d    = is_store_q ? DONE : WAIT;
                end else begin
                    ram_addr_d = addr_q + ADDR_W'(cnt_inc);
                    ram_dout_d = sdata_q[{cnt_inc[1:0], 3'b000} +: 8];
                end
            end
            WAIT: begin
                stall_req        = 1'b1;
                bytes_d[cap_idx] = ram_din;
                state_d          = DONE;
            end
            DONE: begin
                wb_wd_d    = wd_q;
                wb_wreg_d  = wreg_q && !trap_q;
                wb_wdata_d = (is_store_q || trap_q) ? '0 : load_val;
                trap_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= '0;
            sdata_q    <= '0;
            wd_q       <= NULL_WD;
            wreg_q     <= 1'b0;
            cnt_q      <= 3'd0;
            bytes_q    <= '0;
            trap_q     <= 1'b0;
            wb_wd_q    <= NULL_WD;
            wb_wreg_q  <= 1'b0;
            wb_wdata_q <= '0;
            ram_en_q   <= 1'b0;
            ram_wr_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_dout_q <= NULL_BYTE;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            wd_q       <= wd_d;
            wreg_q     <= wreg_d;
            cnt_q      <= cnt_d;
            bytes_q    <= bytes_d;
            trap_q     <= trap_d;
            wb_wd_q    <= wb_wd_d;
            wb_wreg_q  <= wb_wreg_d;
            wb_wdata_q <= wb_wdata_d;
            ram_en_q   <= ram_en_d;
            ram_wr_q   <= ram_wr_d;
            ram_addr_q <= ram_addr_d;
            ram_dout_q <= ram_dout_d;
        end
    end

    assign ram_en   = ram_en_q;
    assign ram_wr   = ram_wr_q;
    assign ram_addr = ram_addr_q;
    assign ram_dout = ram_dout_q;
    assign wb_wd    = wb_wd_q;
    assign wb_wreg  = wb_wreg_q;
    assign wb_wdata = wb_wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized and directed checks of mem_access against a
// byte-array reference model; a separate synchronous RAM model serves the DUT.
module tb_mem_access;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_ADD = 7'b0110011;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  in_wd;
    logic        in_wreg;
    logic [31:0] in_wdata;
    logic [6:0]  in_op;
    logic [2:0]  in_funct3;
    logic [31:0] in_mem_addr;
    logic [31:0] in_reg;
    logic        stall_req;
    logic        ram_en;
    logic        ram_wr;
    logic [31:0] ram_addr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    mem_access dut (
        .clk         (clk),
        .rst         (rst),
        .in_wd       (in_wd),
        .in_wreg     (in_wreg),
        .in_wdata    (in_wdata),
        .in_op       (in_op),
        .in_funct3   (in_funct3),
        .in_mem_addr (in_mem_addr),
        .in_reg      (in_reg),
        .stall_req   (stall_req),
        .ram_en      (ram_en),
        .ram_wr      (ram_wr),
        .ram_addr    (ram_addr),
        .ram_dout    (ram_dout),
        .ram_din     (ram_din),
        .wb_wd       (wb_wd),
        .wb_wreg     (wb_wreg),
        .wb_wdata    (wb_wdata),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Power-on content of every byte not yet written (0x101 holds 0x80).
    function automatic bit [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h80;
    endfunction

    // ---------------- RAM model seen by the DUT ----------------
    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
        int          c;
    } wr_t;

    bit [7:0] ram [bit [31:0]];
    wr_t      wlog[$];
    int       cyc = 0;

    function automatic bit [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_en) begin
            if (ram_wr) begin
                ram[ram_addr] = ram_dout;
                wlog.push_back('{ram_addr, ram_dout, cyc});
            end else begin
                ram_din <= ram_rd(ram_addr);
            end
        end
    end

    // ---------------- Reference model ----------------
    bit [7:0] ref_mem [bit [31:0]];

    function automatic bit [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bubble();
        in_op = 7'd0; in_funct3 = 3'd0; in_mem_addr = 32'd0; in_reg = 32'd0;
        in_wd = 5'd0; in_wreg = 1'b0; in_wdata = 32'd0;
    endtask

    // Present one instruction for a cycle, then bubbles, and check the
    // stall length, RAM traffic and writeback against the reference model.
    task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] wd, input logic wreg,
                          input logic [31:0] wdata);
        bit          is_ld;
        bit          is_st;
        bit          mem;
        bit          trap;
        int          n;
        int          exp_stall;
        int          stall_cnt;
        int          en_cnt;
        int          guard;
        int          wbase;
        logic [31:0] v;
        logic [31:0] exp_data;

        is_ld = (op == OP_LD) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        is_st = (op == OP_ST) && (f3 inside {3'd0, 3'd1, 3'd2});
        mem   = is_ld || is_st;
        n     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        trap  = mem && TRAP && ((n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00));
        exp_stall = !mem ? 0 : trap ? 1 : is_st ? 1 + n : 2 + n;
        wbase = wlog.size();

        @(negedge clk);
        in_op = op; in_funct3 = f3; in_mem_addr = addr; in_reg = sdata;
        in_wd = wd; in_wreg = wreg; in_wdata = wdata;
        #1;

        if (!mem) begin
            check("alu_stall", 32'(stall_req), 32'd0);
            @(negedge clk);
            bubble();
            #1;
            check("alu_wb_wd", 32'(wb_wd), 32'(wd));
            check("alu_wb_wreg", 32'(wb_wreg), 32'(wreg && op != OP_LD && op != OP_ST));
            check("alu_wb_wdata", wb_wdata, wdata);
            check("alu_ram_en", 32'(ram_en), 32'd0);
            return;
        end

        stall_cnt = 0; en_cnt = 0; guard = 0;
        while (stall_req && guard < 20) begin
            stall_cnt++;
            if (ram_en) en_cnt++;
            @(negedge clk);
            bubble();
            #1;
            guard++;
            if (guard == 1) check("wb_bubble_wreg", 32'(wb_wreg), 32'd0);
        end
        check("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
        check("done_ram_en", 32'(ram_en), 32'd0);
        check("ram_en_cycles", 32'(en_cnt), trap ? 32'd0 : 32'(n));

        @(negedge clk);
        #1;
        check("wb_wd", 32'(wb_wd), 32'(wd));
        check("wb_wreg", 32'(wb_wreg), 32'(wreg && !trap));
        check("misalign", 32'(misalign), 32'(trap));
        check("wr_count", 32'(wlog.size() - wbase), (is_st && !trap) ? 32'(n) : 32'd0);

        if (is_st && !trap) begin
            for (int i = 0; i < n && wbase + i < wlog.size(); i++) begin
                check("wr_addr", wlog[wbase + i].a, addr + 32'(i));
                check("wr_data", 32'(wlog[wbase + i].d), 32'(sdata[8*i +: 8]));
                check("wr_cycle", 32'(wlog[wbase + i].c - wlog[wbase].c), 32'(i));
            end
            for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = sdata[8*i +: 8];
            check("st_wb_wdata", wb_wdata, 32'd0);
        end else if (is_ld && !trap) begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = ref_rd(addr + 32'(i));
            case (f3)
                3'd0:    exp_data = {{24{v[7]}}, v[7:0]};
                3'd1:    exp_data = {{16{v[15]}}, v[15:0]};
                3'd4:    exp_data = {24'd0, v[7:0]};
                3'd5:    exp_data = {16'd0, v[15:0]};
                default: exp_data = v;
            endcase
            check("ld_wb_wdata", wb_wdata, exp_data);
        end
    endtask

    logic [6:0]  r_op;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    int          r_kind;

    initial begin
        rst = 1'b1;
        bubble();
        repeat (3) @(negedge clk);
        #1;
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_wr", 32'(ram_wr), 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_dout", 32'(ram_dout), 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_wb_wd", 32'(wb_wd), 32'd0);
        check("rst_wb_wreg", 32'(wb_wreg), 32'd0);
        check("rst_wb_wdata", wb_wdata, 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        rst = 1'b0;

        // Directed cases.
        run_op(OP_ADD, 3'd0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234);
        run_op(OP_LD, 3'd0, 32'h101, 32'h0, 5'd3, 1'b1, 32'h0);   // LB  -> 0xFFFFFF80
        check("lb_value", wb_wdata, 32'hFFFFFF80);
        run_op(OP_LD, 3'd4, 32'h101, 32'h0, 5'd4, 1'b1, 32'h0);   // LBU -> 0x00000080
        check("lbu_value", wb_wdata, 32'h00000080);
        run_op(OP_ST, 3'd2, 32'h100, 32'hDEADBEEF, 5'd0, 1'b0, 32'h0);
        run_op(OP_LD, 3'd2, 32'h100, 32'h0, 5'd7, 1'b1, 32'h0);
        check("lw_value", wb_wdata, 32'hDEADBEEF);
        run_op(OP_LD, 3'd2, 32'h102, 32'h0, 5'd9, 1'b1, 32'h0);   // misaligned LW
        run_op(OP_LD, 3'd3, 32'h100, 32'h0, 5'd6, 1'b1, 32'h55);  // bad funct3
        run_op(OP_ST, 3'd2, 32'hFFFFFFFE, 32'hA1B2C3D4, 5'd0, 1'b0, 32'h0);
        run_op(OP_LD, 3'd2, 32'hFFFFFFFE, 32'h0, 5'd8, 1'b1, 32'h0);

        // Reset in the middle of a SW: bytes 0-1 reach RAM, 2-3 do not.
        @(negedge clk);
        in_op = OP_ST; in_funct3 = 3'd2; in_mem_addr = 32'h200; in_reg = 32'h11223344;
        @(negedge clk);
        bubble();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_ram_en", 32'(ram_en), 32'd0);
        check("midrst_stall", 32'(stall_req), 32'd0);
        check("midrst_wb_wreg", 32'(wb_wreg), 32'd0);
        check("midrst_b0", 32'(ram_rd(32'h200)), 32'h44);
        check("midrst_b1", 32'(ram_rd(32'h201)), 32'h33);
        check("midrst_b2", 32'(ram_rd(32'h202)), 32'(ref_rd(32'h202)));
        check("midrst_b3", 32'(ram_rd(32'h203)), 32'(ref_rd(32'h203)));
        ref_mem[32'h200] = 8'h44;
        ref_mem[32'h201] = 8'h33;
        rst = 1'b0;
        run_op(OP_LD, 3'd2, 32'h200, 32'h0, 5'd10, 1'b1, 32'h0);

        // Randomized mix of ALU ops, loads, stores and bad funct3 values.
        for (int k = 0; k < 150; k++) begin
            r_kind = int'($urandom_range(0, 3));
            case (r_kind)
                0: begin
                    r_op = 7'($urandom);
                    if (r_op == OP_LD || r_op == OP_ST) r_op = r_op ^ 7'h10;
                    r_f3 = 3'($urandom);
                end
                1: begin
                    r_op = OP_LD;
                    case ($urandom_range(0, 4))
                        0: r_f3 = 3'd0;
                        1: r_f3 = 3'd1;
                        2: r_f3 = 3'd2;
                        3: r_f3 = 3'd4;
                        default: r_f3 = 3'd5;
                    endcase
                end
                2: begin
                    r_op = OP_ST;
                    r_f3 = 3'($urandom_range(0, 2));
                end
                default: begin
                    r_op = ($urandom_range(0, 1) == 0) ? OP_LD : OP_ST;
                    if (r_op == OP_LD) r_f3 = ($urandom_range(0, 2) == 0) ? 3'd3 : 3'($urandom_range(6, 7));
                    else               r_f3 = 3'($urandom_range(3, 7));
                end
            endcase
            if ($urandom_range(0, 3) == 0) r_addr = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
            else                           r_addr = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 1) == 0) begin
                if (r_f3[1:0] == 2'b01) r_addr[0] = 1'b0;
                if (r_f3[1:0] == 2'b10) r_addr[1:0] = 2'b00;
            end
            run_op(r_op, r_f3, r_addr, $urandom, 5'($urandom),
                   (r_op == OP_ST) ? 1'b0 : 1'($urandom), $urandom);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
